// File: rtl/icache.sv
// Direct-mapped instruction cache: 16 one-word lines, 1-cycle hit, blocking
// single-word fill from the memory controller, flush-aware delivery.
module icache (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic        busy,
  output logic        inst_rdy,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_inst_rdy,
  input  logic [31:0] mem_inst
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned LINES = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned TAG_W = 12;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               drop_q, drop_d;
  logic [XLEN-1:0]    miss_pc_q, miss_pc_d;
  logic               inst_rdy_d, mem_req_d;
  logic [XLEN-1:0]    inst_out_d, pc_out_d, mem_addr_d;
  logic               fill_c;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [XLEN-1:0]    data_q [LINES];

  logic [IDX_W-1:0]   req_idx, miss_idx;
  logic [TAG_W-1:0]   req_tag, miss_tag;
  logic               hit_c;

  assign req_idx  = if_pc[5:2];
  assign req_tag  = if_pc[17:6];
  assign miss_idx = miss_pc_q[5:2];
  assign miss_tag = miss_pc_q[17:6];
  assign hit_c    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign busy     = (state_q == MISS);

  // State register
  always_ff @(posedge clk) begin
    if (rst_in)      state_q <= IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  // Next-state logic; a flushed request is wrong-path and never starts a fill
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (if_req && !flush && !hit_c) state_d = MISS;
      MISS: if (mem_inst_rdy)               state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    inst_rdy_d = 1'b0;
    inst_out_d = inst_out;
    pc_out_d   = pc_out;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    miss_pc_d  = miss_pc_q;
    drop_d     = drop_q;
    fill_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req && hit_c) begin
          inst_rdy_d = !flush;
          inst_out_d = data_q[req_idx];
          pc_out_d   = if_pc;
        end else if (if_req && !flush) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {if_pc[31:2], 2'b00};
          miss_pc_d  = if_pc;
        end
      end
      MISS: begin
        if (mem_inst_rdy) begin
          fill_c     = 1'b1;
          mem_req_d  = 1'b0;
          inst_rdy_d = !drop_q && !flush;
          inst_out_d = mem_inst;
          pc_out_d   = miss_pc_q;
          drop_d     = 1'b0;
        end else if (flush) begin
          drop_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and control state
  always_ff @(posedge clk) begin
    if (rst_in) begin
      drop_q    <= 1'b0;
      miss_pc_q <= '0;
      inst_rdy  <= 1'b0;
      inst_out  <= '0;
      pc_out    <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      valid_q   <= '0;
    end else if (rdy_in) begin
      drop_q    <= drop_d;
      miss_pc_q <= miss_pc_d;
      inst_rdy  <= inst_rdy_d;
      inst_out  <= inst_out_d;
      pc_out    <= pc_out_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      if (fill_c) valid_q[miss_idx] <= 1'b1;
    end
  end

  // Line data and tags carry no reset
  always_ff @(posedge clk) begin
    if (!rst_in && rdy_in && fill_c) begin
      data_q[miss_idx] <= mem_inst;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, hit, conflict, flush,
// stall and reset-during-miss scenarios.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, if_req, flush, mem_inst_rdy;
  logic [31:0] if_pc, mem_inst;
  logic        busy, inst_rdy, mem_req;
  logic [31:0] inst_out, pc_out, mem_addr;

  int passed = 0;
  int total  = 0;

  icache dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .if_req(if_req), .if_pc(if_pc),
    .flush(flush), .busy(busy), .inst_rdy(inst_rdy), .inst_out(inst_out),
    .pc_out(pc_out), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_inst_rdy(mem_inst_rdy), .mem_inst(mem_inst)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] pc, input logic fl);
    if_req = 1'b1; if_pc = pc; flush = fl;
    step();
    if_req = 1'b0; flush = 1'b0;
  endtask

  task automatic fill(input logic [31:0] d, input logic fl);
    mem_inst_rdy = 1'b1; mem_inst = d; flush = fl;
    step();
    mem_inst_rdy = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step(); step();
    rst_in = 1'b0;
    total++; if (inst_rdy !== 1'b0) $display("FAIL rst_inst_rdy: got %0b want 0", inst_rdy); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %0b want 0", mem_req); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passed++;
    total++; if (inst_out !== 32'h0) $display("FAIL rst_inst_out: got %h want 0", inst_out); else passed++;
    total++; if (pc_out !== 32'h0) $display("FAIL rst_pc_out: got %h want 0", pc_out); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else passed++;
  endtask

  task automatic test_cold_miss();
    request(32'h0000_1004, 1'b0);
    total++; if (mem_req !== 1'b1) $display("FAIL cold_mem_req: got %0b want 1", mem_req); else passed++;
    total++; if (mem_addr !== 32'h0000_1004) $display("FAIL cold_mem_addr: got %h want 00001004", mem_addr); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL cold_busy: got %0b want 1", busy); else passed++;
    total++; if (inst_rdy !== 1'b0) $display("FAIL cold_early_rdy: got %0b want 0", inst_rdy); else passed++;
    if_req = 1'b1; if_pc = 32'h0000_2000;
    step();
    if_req = 1'b0;
    total++; if (mem_addr !== 32'h0000_1004) $display("FAIL cold_addr_hold: got %h want 00001004", mem_addr); else passed++;
    total++; if (mem_req !== 1'b1) $display("FAIL cold_req_hold: got %0b want 1", mem_req); else passed++;
    fill(32'h0000_0513, 1'b0);
    total++; if (inst_rdy !== 1'b1) $display("FAIL cold_inst_rdy: got %0b want 1", inst_rdy); else passed++;
    total++; if (inst_out !== 32'h0000_0513) $display("FAIL cold_inst_out: got %h want 00000513", inst_out); else passed++;
    total++; if (pc_out !== 32'h0000_1004) $display("FAIL cold_pc_out: got %h want 00001004", pc_out); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL cold_req_drop: got %0b want 0", mem_req); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL cold_busy_drop: got %0b want 0", busy); else passed++;
    step();
    total++; if (inst_rdy !== 1'b0) $display("FAIL cold_pulse_width: got %0b want 0", inst_rdy); else passed++;
  endtask

  task automatic test_hit();
    request(32'h0000_1004, 1'b0);
    total++; if (inst_rdy !== 1'b1) $display("FAIL hit_inst_rdy: got %0b want 1", inst_rdy); else passed++;
    total++; if (inst_out !== 32'h0000_0513) $display("FAIL hit_inst_out: got %h want 00000513", inst_out); else passed++;
    total++; if (pc_out !== 32'h0000_1004) $display("FAIL hit_pc_out: got %h want 00001004", pc_out); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL hit_mem_req: got %0b want 0", mem_req); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL hit_busy: got %0b want 0", busy); else passed++;
    step();
    total++; if (inst_rdy !== 1'b0) $display("FAIL hit_pulse_width: got %0b want 0", inst_rdy); else passed++;
  endtask

  task automatic test_conflict();
    request(32'h0000_1044, 1'b0);
    total++; if (mem_req !== 1'b1) $display("FAIL conf_miss1: got %0b want 1", mem_req); else passed++;
    total++; if (mem_addr !== 32'h0000_1044) $display("FAIL conf_addr1: got %h want 00001044", mem_addr); else passed++;
    fill(32'hAAAA_0001, 1'b0);
    total++; if (inst_out !== 32'hAAAA_0001) $display("FAIL conf_inst1: got %h want aaaa0001", inst_out); else passed++;
    total++; if (pc_out !== 32'h0000_1044) $display("FAIL conf_pc1: got %h want 00001044", pc_out); else passed++;
    request(32'h0000_1004, 1'b0);
    total++; if (mem_req !== 1'b1) $display("FAIL conf_miss2: got %0b want 1", mem_req); else passed++;
    total++; if (inst_rdy !== 1'b0) $display("FAIL conf_no_hit2: got %0b want 0", inst_rdy); else passed++;
    fill(32'h0000_0513, 1'b0);
    total++; if (inst_rdy !== 1'b1) $display("FAIL conf_rdy2: got %0b want 1", inst_rdy); else passed++;
  endtask

  task automatic test_flush_miss();
    request(32'h0000_2008, 1'b0);
    total++; if (mem_req !== 1'b1) $display("FAIL fmiss_req: got %0b want 1", mem_req); else passed++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL fmiss_busy: got %0b want 1", busy); else passed++;
    total++; if (mem_addr !== 32'h0000_2008) $display("FAIL fmiss_addr: got %h want 00002008", mem_addr); else passed++;
    fill(32'h1234_5678, 1'b0);
    total++; if (inst_rdy !== 1'b0) $display("FAIL fmiss_dropped: got %0b want 0", inst_rdy); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL fmiss_idle: got %0b want 0", busy); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL fmiss_req_drop: got %0b want 0", mem_req); else passed++;
    request(32'h0000_2008, 1'b0);
    total++; if (inst_rdy !== 1'b1) $display("FAIL fmiss_rehit: got %0b want 1", inst_rdy); else passed++;
    total++; if (inst_out !== 32'h1234_5678) $display("FAIL fmiss_rehit_data: got %h want 12345678", inst_out); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL fmiss_rehit_req: got %0b want 0", mem_req); else passed++;
  endtask

  task automatic test_flush_hit();
    request(32'h0000_2008, 1'b1);
    total++; if (inst_rdy !== 1'b0) $display("FAIL fhit_suppress: got %0b want 0", inst_rdy); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL fhit_busy: got %0b want 0", busy); else passed++;
  endtask

  task automatic test_flush_with_fill();
    request(32'h0000_4010, 1'b0);
    fill(32'h0BAD_F00D, 1'b1);
    total++; if (inst_rdy !== 1'b0) $display("FAIL ffill_suppress: got %0b want 0", inst_rdy); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ffill_idle: got %0b want 0", busy); else passed++;
    request(32'h0000_4010, 1'b0);
    total++; if (inst_rdy !== 1'b1) $display("FAIL ffill_written: got %0b want 1", inst_rdy); else passed++;
    total++; if (inst_out !== 32'h0BAD_F00D) $display("FAIL ffill_data: got %h want 0badf00d", inst_out); else passed++;
  endtask

  task automatic test_stall();
    request(32'h0000_300C, 1'b0);
    rdy_in = 1'b0; mem_inst_rdy = 1'b1; mem_inst = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (busy !== 1'b1 || mem_req !== 1'b1 || inst_rdy !== 1'b0)
        $display("FAIL stall_hold%0d: got busy=%0b req=%0b rdy=%0b want 1 1 0", i, busy, mem_req, inst_rdy);
      else passed++;
    end
    rdy_in = 1'b1;
    step();
    mem_inst_rdy = 1'b0;
    total++; if (inst_rdy !== 1'b1) $display("FAIL stall_done: got %0b want 1", inst_rdy); else passed++;
    total++; if (inst_out !== 32'hDEAD_BEEF) $display("FAIL stall_data: got %h want deadbeef", inst_out); else passed++;
    total++; if (pc_out !== 32'h0000_300C) $display("FAIL stall_pc: got %h want 0000300c", pc_out); else passed++;
  endtask

  task automatic test_reset_mid_miss();
    request(32'h0000_5014, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL rmiss_busy: got %0b want 1", busy); else passed++;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rmiss_idle: got %0b want 0", busy); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL rmiss_req: got %0b want 0", mem_req); else passed++;
    fill(32'h5555_AAAA, 1'b0);
    total++; if (inst_rdy !== 1'b0) $display("FAIL rmiss_late_fill: got %0b want 0", inst_rdy); else passed++;
    request(32'h0000_5014, 1'b0);
    total++; if (mem_req !== 1'b1) $display("FAIL rmiss_remiss: got %0b want 1", mem_req); else passed++;
    total++; if (mem_addr !== 32'h0000_5014) $display("FAIL rmiss_addr: got %h want 00005014", mem_addr); else passed++;
    fill(32'h0000_0013, 1'b0);
    total++; if (inst_rdy !== 1'b1) $display("FAIL rmiss_final: got %0b want 1", inst_rdy); else passed++;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; flush = 1'b0;
    if_pc = 32'h0; mem_inst_rdy = 1'b0; mem_inst = 32'h0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush_miss();
    test_flush_hit();
    test_flush_with_fill();
    test_stall();
    test_reset_mid_miss();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
